// File: rtl/conv_mix_pkg.sv
// Shared encodings and helpers for the post-convolution mix stage.
// Pure declarations; no timing or flow-control behaviour.
package conv_mix_pkg;
  localparam int   DW_DEF      = 16;
  localparam logic MODE_PER_CH = 1'b0;
  localparam logic MODE_SUM    = 1'b1;

  function automatic int clog2c(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Clamp a wide signed value into the signed range of a dw-bit result.
  function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/conv_sum_tree.sv
// Registered saturating adder tree over CH signed lanes; latency clog2(CH) cycles.
// No backpressure: a valid bit rides alongside the data through every level.
module conv_sum_tree
  import conv_mix_pkg::*;
#(
  parameter int CH = 6,
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_vld,
  input  logic [CH*DW-1:0] din,
  output logic             sum_vld,
  output logic [DW-1:0]    sum,
  output logic             sat
);
  localparam int NL = clog2c(CH);
  localparam int SW = DW + NL;

  logic signed [SW-1:0] ext [CH];

  for (genvar i = 0; i < CH; i++) begin : g_ext
    assign ext[i] = SW'($signed(din[i*DW +: DW]));
  end

  for (genvar k = 1; k <= NL; k++) begin : g_lvl
    localparam int NP = (CH + (1 << (k - 1)) - 1) >> (k - 1);
    localparam int NN = (CH + (1 << k) - 1) >> k;

    logic signed [SW-1:0] src [NP];
    logic                 src_vld;
    logic signed [SW-1:0] nxt [NN];
    logic signed [SW-1:0] val [NN];
    logic                 vld;

    if (k == 1) begin : g_first
      assign src     = ext;
      assign src_vld = in_vld;
    end else begin : g_next
      assign src     = g_lvl[k-1].val;
      assign src_vld = g_lvl[k-1].vld;
    end

    // Pair up neighbours; an odd trailing lane passes straight to the next level.
    for (genvar j = 0; j < NN; j++) begin : g_node
      if (2 * j + 1 < NP) begin : g_add
        assign nxt[j] = src[2*j] + src[2*j+1];
      end else begin : g_pass
        assign nxt[j] = src[2*j];
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld <= 1'b0;
        for (int j = 0; j < NN; j++) val[j] <= '0;
      end else begin
        vld <= src_vld;
        for (int j = 0; j < NN; j++) val[j] <= nxt[j];
      end
    end
  end

  logic signed [63:0] wide;
  logic signed [63:0] clip;

  assign wide    = 64'(g_lvl[NL].val[0]);
  assign clip    = sat_to_dw(wide, DW);
  assign sat     = (wide != clip);
  assign sum     = clip[DW-1:0];
  assign sum_vld = g_lvl[NL].vld;
endmodule

// File: rtl/conv_mix_post.sv
// Post-conv stage: per-lane passthrough or lane sum, ReLU, frame beat count; latency clog2(CH)+1.
// No backpressure: partial-valid beats are dropped, win_start doubles as upstream ready.
module conv_mix_post
  import conv_mix_pkg::*;
#(
  parameter int CH    = 6,
  parameter int DW    = DW_DEF,
  parameter int DLY_W = 8,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             mode,
  input  logic             relu_en,
  input  logic [DLY_W-1:0] win_delay,
  input  logic [CNT_W-1:0] frame_len,
  input  logic [CH-1:0]    conv_valid,
  input  logic [CH*DW-1:0] conv_din,
  output logic             win_start,
  output logic [CH*DW-1:0] dout,
  output logic             ovalid,
  output logic             done,
  output logic             sat_flag
);
  localparam int NL = clog2c(CH);

  logic             start_q;
  logic             start_rise;
  logic             mode_q;
  logic [DLY_W-1:0] dly_cnt;
  logic [CNT_W-1:0] beat_cnt;
  logic             beat_vld;
  logic             tree_vld;
  logic             tree_sat;
  logic [DW-1:0]    tree_sum;
  logic [CH*DW-1:0] byp [NL];
  logic [CH*DW-1:0] mix;
  logic [CH*DW-1:0] relu;

  assign start_rise = start & ~start_q;
  assign beat_vld   = &conv_valid;

  conv_sum_tree #(
    .CH (CH),
    .DW (DW)
  ) u_tree (
    .clk     (clk),
    .rstn    (rstn),
    .in_vld  (beat_vld),
    .din     (conv_din),
    .sum_vld (tree_vld),
    .sum     (tree_sum),
    .sat     (tree_sat)
  );

  // Bypass lanes are delayed to line up with the tree output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NL; i++) byp[i] <= '0;
    end else begin
      byp[0] <= conv_din;
      for (int i = 1; i < NL; i++) byp[i] <= byp[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q   <= 1'b0;
      win_start <= 1'b0;
      dly_cnt   <= '0;
    end else begin
      start_q <= start;
      if (!start) begin
        win_start <= 1'b0;
        dly_cnt   <= '0;
      end else if (start_rise && !win_start) begin
        if (win_delay == '0) win_start <= 1'b1;
        else                 dly_cnt   <= win_delay;
      end else if (dly_cnt != '0) begin
        if (dly_cnt == DLY_W'(1)) win_start <= 1'b1;
        dly_cnt <= dly_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    mix  = (mode_q == MODE_SUM) ? {CH{tree_sum}} : byp[NL-1];
    relu = mix;
    for (int i = 0; i < CH; i++) begin
      if (relu_en && mix[i*DW + DW-1]) relu[i*DW +: DW] = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout   <= '0;
      ovalid <= 1'b0;
    end else begin
      dout   <= relu;
      ovalid <= tree_vld;
    end
  end

  // A start edge restarts the frame and takes priority over a coincident output beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q   <= MODE_PER_CH;
      sat_flag <= 1'b0;
      beat_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_rise) begin
        mode_q   <= mode;
        sat_flag <= 1'b0;
        beat_cnt <= '0;
      end else begin
        if (tree_vld && tree_sat && (mode_q == MODE_SUM)) sat_flag <= 1'b1;
        if (ovalid) begin
          if ((frame_len != '0) && (beat_cnt == frame_len - 1'b1)) begin
            beat_cnt <= '0;
            done     <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_mix_post.sv
// Directed bench for conv_mix_post: vector table for the datapath, hand sequences for timing corners.
module tb_conv_mix_post;
  localparam int CH    = 6;
  localparam int DW    = 16;
  localparam int DLY_W = 8;
  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic             mode;
  logic             relu_en;
  logic [DLY_W-1:0] win_delay;
  logic [CNT_W-1:0] frame_len;
  logic [CH-1:0]    conv_valid;
  logic [CH*DW-1:0] conv_din;
  logic             win_start;
  logic [CH*DW-1:0] dout;
  logic             ovalid;
  logic             done;
  logic             sat_flag;

  conv_mix_post #(
    .CH (CH), .DW (DW), .DLY_W (DLY_W), .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .mode       (mode),
    .relu_en    (relu_en),
    .win_delay  (win_delay),
    .frame_len  (frame_len),
    .conv_valid (conv_valid),
    .conv_din   (conv_din),
    .win_start  (win_start),
    .dout       (dout),
    .ovalid     (ovalid),
    .done       (done),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             m;
    logic             r;
    logic [CH*DW-1:0] din;
    logic [CH*DW-1:0] exp;
    logic             sat;
  } vec_t;

  vec_t vecs [9];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CH*DW-1:0] p6(input logic [DW-1:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [CH*DW-1:0] rep(input logic [DW-1:0] a);
    return {CH{a}};
  endfunction

  function automatic vec_t mk(input logic m, input logic r, input logic [CH*DW-1:0] d,
                              input logic [CH*DW-1:0] e, input logic s);
    vec_t v;
    v.m = m; v.r = r; v.din = d; v.exp = e; v.sat = s;
    return v;
  endfunction

  task automatic new_frame(input logic m);
    start = 1'b0;
    mode  = m;
    tick();
    start = 1'b1;
    tick();
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    new_frame(v.m);
    relu_en    = v.r;
    conv_valid = '1;
    conv_din   = v.din;
    tick();
    conv_valid = '0;
    conv_din   = '0;
    tick();
    tick();
    chk($sformatf("vec%0d ovalid_early", idx), ovalid, 1'b0);
    tick();
    chk($sformatf("vec%0d ovalid", idx), ovalid, 1'b1);
    chk($sformatf("vec%0d dout", idx), dout, v.exp);
    chk($sformatf("vec%0d sat_flag", idx), sat_flag, v.sat);
    tick();
    chk($sformatf("vec%0d ovalid_after", idx), ovalid, 1'b0);
  endtask

  task automatic win_test(input int d, input int exp_c);
    int c;
    start     = 1'b0;
    win_delay = DLY_W'(d);
    tick();
    tick();
    start = 1'b1;
    c = 0;
    while (!win_start && c < 300) begin
      tick();
      c++;
    end
    chk($sformatf("win_delay%0d rise_cycle", d), c, exp_c);
    tick();
    tick();
    chk($sformatf("win_delay%0d held", d), win_start, 1'b1);
    start = 1'b0;
    tick();
    chk($sformatf("win_delay%0d drop", d), win_start, 1'b0);
  endtask

  // Full beats on even cycles, optional partial beat at part_at, then drain.
  task automatic run_beats(input int nb, input int part_at, output int n_ov, output int n_dn,
                           output int last_ov, output int dn_t);
    n_ov = 0; n_dn = 0; last_ov = -1; dn_t = -1;
    for (int t = 0; t < 2 * nb + 12; t++) begin
      if (t % 2 == 0 && t / 2 < nb) begin
        conv_valid = '1;
        conv_din   = rep(DW'(t));
      end else if (t == part_at) begin
        conv_valid = 6'b011111;
        conv_din   = rep(16'h0055);
      end else begin
        conv_valid = '0;
      end
      tick();
      if (ovalid) begin n_ov++; last_ov = t; end
      if (done)   begin n_dn++; dn_t = t; end
    end
    conv_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_ov, n_dn, last_ov, dn_t, cnt;

    vecs[0] = mk(1'b1, 1'b0, p6(1, 2, 3, 4, 5, 6), rep(16'd21), 1'b0);
    vecs[1] = mk(1'b1, 1'b0, rep(16'h7000), rep(16'h7FFF), 1'b1);
    vecs[2] = mk(1'b1, 1'b0, rep(16'h9000), rep(16'h8000), 1'b1);
    vecs[3] = mk(1'b0, 1'b1, p6(16'hFFFB, 7, 3, 3, 3, 3), p6(0, 7, 3, 3, 3, 3), 1'b0);
    vecs[4] = mk(1'b0, 1'b0, p6(16'hFFFB, 7, 3, 3, 3, 3), p6(16'hFFFB, 7, 3, 3, 3, 3), 1'b0);
    vecs[5] = mk(1'b1, 1'b1, p6(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA), rep(16'h0000), 1'b0);
    vecs[6] = mk(1'b1, 1'b0, p6(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA), rep(16'hFFEB), 1'b0);
    vecs[7] = mk(1'b1, 1'b0, p6(16'h7FFF, 1, 0, 0, 0, 0), rep(16'h7FFF), 1'b1);
    vecs[8] = mk(1'b0, 1'b0, rep(16'h7000), rep(16'h7000), 1'b0);

    rstn = 1'b1; start = 1'b0; mode = 1'b0; relu_en = 1'b0;
    win_delay = '0; frame_len = '0; conv_valid = '0; conv_din = '0;
    #2 rstn = 1'b0;
    tick();
    tick();
    chk("reset win_start", win_start, 1'b0);
    chk("reset dout", dout, '0);
    chk("reset ovalid", ovalid, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset sat_flag", sat_flag, 1'b0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(i);
    relu_en = 1'b0;

    win_test(0, 1);
    win_test(9, 10);
    win_test(89, 90);
    win_delay = '0;

    // 64 beats with gaps plus one dropped partial beat.
    frame_len = 10'd64;
    new_frame(1'b0);
    run_beats(64, 21, n_ov, n_dn, last_ov, dn_t);
    chk("frame64 ovalid_count", n_ov, 64);
    chk("frame64 done_count", n_dn, 1);
    chk("frame64 done_timing", dn_t, last_ov + 1);

    frame_len = 10'd2;
    run_beats(2, -1, n_ov, n_dn, last_ov, dn_t);
    chk("counter_cleared done_count", n_dn, 1);
    chk("counter_cleared done_timing", dn_t, last_ov + 1);

    frame_len = '0;
    run_beats(5, -1, n_ov, n_dn, last_ov, dn_t);
    chk("frame_len0 ovalid_count", n_ov, 5);
    chk("frame_len0 done_count", n_dn, 0);

    // Start edge landing on an output beat wins; that beat is not counted.
    frame_len = 10'd1;
    new_frame(1'b0);
    start      = 1'b0;
    conv_valid = '1;
    conv_din   = rep(16'd4);
    tick();
    conv_valid = '0;
    tick();
    tick();
    tick();
    chk("rise_vs_beat ovalid", ovalid, 1'b1);
    start = 1'b1;
    tick();
    chk("rise_vs_beat done", done, 1'b0);
    run_beats(1, -1, n_ov, n_dn, last_ov, dn_t);
    chk("rise_vs_beat next_done", n_dn, 1);
    frame_len = '0;

    // Mode changes after the start edge are ignored.
    new_frame(1'b1);
    mode       = 1'b0;
    conv_valid = '1;
    conv_din   = p6(1, 2, 3, 4, 5, 6);
    tick();
    conv_valid = '0;
    tick(); tick(); tick();
    chk("mode_latched sum dout", dout, rep(16'd21));
    new_frame(1'b0);
    mode       = 1'b1;
    conv_valid = '1;
    conv_din   = p6(1, 2, 3, 4, 5, 6);
    tick();
    conv_valid = '0;
    tick(); tick(); tick();
    chk("mode_latched perch dout", dout, p6(1, 2, 3, 4, 5, 6));

    // Reset in the middle of a stream.
    new_frame(1'b1);
    conv_valid = '1;
    conv_din   = rep(16'h7000);
    tick();
    conv_din   = p6(1, 2, 3, 4, 5, 6);
    tick();
    conv_valid = '0;
    tick(); tick();
    chk("pre_reset sat_flag", sat_flag, 1'b1);
    rstn = 1'b0;
    #2;
    chk("midreset dout", dout, '0);
    chk("midreset ovalid", ovalid, 1'b0);
    chk("midreset sat_flag", sat_flag, 1'b0);
    chk("midreset win_start", win_start, 1'b0);
    tick();
    rstn = 1'b1;
    cnt = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (ovalid) cnt++;
    end
    chk("post_reset no_ovalid", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
